// File: rtl/adder_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : adder_job_dispatcher
//  Description : Feeder / collector wrapped around a sequential adder.
//                Operand pairs arrive over a valid/ready stream into a small
//                FIFO. One job at a time goes to the adder through its
//                start/done handshake. Each result is held in an output
//                register and offered over a valid/ready stream.
//
//  Parameters  : WIDTH   - operand width (adder result is WIDTH+1 bits)
//                DEPTH   - operand FIFO entries (power of 2, >= 2)
//                TIMEOUT - WAIT-state cycle limit (timeout build only)
//
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                in_valid/in_ready    - operand stream handshake
//                in_a, in_b           - operand pair
//                add_start            - one-cycle start pulse to the adder
//                add_a, add_b         - registered operands to the adder
//                add_done             - adder completion (sampled in WAIT)
//                add_sum/add_overflow - adder result, forwarded bit-exact
//                out_valid/out_ready  - result stream handshake
//                out_sum/out_overflow - held result
//                out_timeout          - result was aborted by timeout
//                busy                 - FSM not idle or FIFO non-empty
//                fifo_count           - FIFO occupancy
//
//  Build macro : ADDER_DISPATCH_TIMEOUT_EN - when defined, a WAIT-state
//                cycle counter aborts a job after TIMEOUT cycles without
//                add_done. When undefined, WAIT waits indefinitely and
//                out_timeout is tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_job_dispatcher #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   add_start,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic                   add_done,
    input  logic [WIDTH:0]         add_sum,
    input  logic                   add_overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH:0]         out_sum,
    output logic                   out_overflow,
    output logic                   out_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int                  c_ADDR_W  = $clog2(DEPTH);
    localparam int                  c_CNT_W   = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE = c_ADDR_W'(1);

    // Reject configurations the pointer arithmetic cannot support.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
            $error("adder_job_dispatcher: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                 r_state_q,   w_state_d;
    logic [2*WIDTH-1:0]     r_mem_q [DEPTH];
    logic [c_ADDR_W-1:0]    r_wr_ptr_q,  w_wr_ptr_d;
    logic [c_ADDR_W-1:0]    r_rd_ptr_q,  w_rd_ptr_d;
    logic [c_CNT_W-1:0]     r_count_q,   w_count_d;
    logic [WIDTH-1:0]       r_add_a_q,   w_add_a_d;
    logic [WIDTH-1:0]       r_add_b_q,   w_add_b_d;
    logic [WIDTH:0]         r_out_sum_q, w_out_sum_d;
    logic                   r_out_ovf_q, w_out_ovf_d;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_timeout;
    logic                   w_add_start;
    logic [2*WIDTH-1:0]     w_head;

    // ------------------------------------------------------------------
    // Operand FIFO. in_ready looks only at the registered count, so a pop
    // in the same cycle never lets a push into a full FIFO.
    // ------------------------------------------------------------------
    assign in_ready = (r_count_q < c_FULL);
    assign w_push   = in_valid & in_ready;
    assign w_head   = r_mem_q[r_rd_ptr_q];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_ONE;
            2'b01:   w_count_d = r_count_q - c_CNT_ONE;
            default: w_count_d = r_count_q;
        endcase
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= {in_a, in_b};
        end
    end

    // ------------------------------------------------------------------
    // Job FSM. add_done is looked at only in WAIT, so a done level left
    // over from the previous job cannot complete the next one early.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_add_a_d   = r_add_a_q;
        w_add_b_d   = r_add_b_q;
        w_out_sum_d = r_out_sum_q;
        w_out_ovf_d = r_out_ovf_q;
        w_pop       = 1'b0;
        w_add_start = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (r_count_q != '0) begin
                    // Operands are loaded only here, so they stay put
                    // for the whole ISSUE/WAIT span.
                    {w_add_a_d, w_add_b_d} = w_head;
                    w_state_d              = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_add_start = 1'b1;
                w_state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (add_done) begin
                    w_out_sum_d = add_sum;
                    w_out_ovf_d = add_overflow;
                    w_pop       = 1'b1;
                    w_state_d   = ST_HOLD;
                end else if (w_timeout) begin
                    w_out_sum_d = '0;
                    w_out_ovf_d = 1'b0;
                    w_pop       = 1'b1;
                    w_state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= ST_IDLE;
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_count_q   <= '0;
            r_add_a_q   <= '0;
            r_add_b_q   <= '0;
            r_out_sum_q <= '0;
            r_out_ovf_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_count_q   <= w_count_d;
            r_add_a_q   <= w_add_a_d;
            r_add_b_q   <= w_add_b_d;
            r_out_sum_q <= w_out_sum_d;
            r_out_ovf_q <= w_out_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT-state timeout.
    // ------------------------------------------------------------------
`ifdef ADDER_DISPATCH_TIMEOUT_EN
    localparam int                c_TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_wait_cnt_q, w_wait_cnt_d;
    logic              r_out_to_q,   w_out_to_d;

    // The counter sits at zero outside WAIT, which gives the clear on entry.
    // It holds the number of WAIT cycles already spent without add_done, so
    // reaching TIMEOUT-1 means this is the TIMEOUT-th such cycle.
    always_comb begin
        w_wait_cnt_d = '0;
        if (r_state_q == ST_WAIT) begin
            w_wait_cnt_d = r_wait_cnt_q + c_TO_ONE;
        end
    end

    assign w_timeout = (r_state_q == ST_WAIT) && (r_wait_cnt_q == c_TO_LAST);

    always_comb begin
        w_out_to_d = r_out_to_q;
        if (r_state_q == ST_WAIT && !add_done && w_timeout) begin
            w_out_to_d = 1'b1;
        end else if (r_state_q == ST_HOLD && out_ready) begin
            w_out_to_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt_q <= '0;
            r_out_to_q   <= 1'b0;
        end else begin
            r_wait_cnt_q <= w_wait_cnt_d;
            r_out_to_q   <= w_out_to_d;
        end
    end

    assign out_timeout = r_out_to_q;
`else
    assign w_timeout   = 1'b0;
    assign out_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign add_start    = w_add_start;
    assign add_a        = r_add_a_q;
    assign add_b        = r_add_b_q;
    assign out_valid    = (r_state_q == ST_HOLD);
    assign out_sum      = r_out_sum_q;
    assign out_overflow = r_out_ovf_q;
    assign busy         = (r_state_q != ST_IDLE) || (r_count_q != '0);
    assign fifo_count   = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_job_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_adder_job_dispatcher
//  Description : Self-checking bench for adder_job_dispatcher. A stand-in
//                adder answers add_start after a programmable latency. A
//                transaction-level model (queues of accepted pairs and
//                expected results, occupancy as accepted-minus-completed)
//                is compared against the DUT every cycle. Directed cases
//                pin the model with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_job_dispatcher;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a, in_b;
    logic              add_start;
    logic [WIDTH-1:0]  add_a, add_b;
    logic              add_done;
    logic [WIDTH:0]    add_sum;
    logic              add_overflow;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH:0]    out_sum;
    logic              out_overflow;
    logic              out_timeout;
    logic              busy;
    logic [$clog2(DEPTH):0] fifo_count;

    adder_job_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_sum(add_sum), .add_overflow(add_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .out_timeout(out_timeout),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Stand-in adder. Overflow flag rule of this stand-in: set when both
    // operands are equal and non-zero (the dispatcher only forwards it).
    // ------------------------------------------------------------------
    function automatic logic model_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    int              lat_min    = 1;
    int              lat_max    = 3;
    bit              stale_mode = 1'b0;
    bit              no_resp    = 1'b0;
    bit              pend       = 1'b0;
    bit              done_real  = 1'b0;
    int              lat_cnt    = 0;
    logic [WIDTH-1:0] ma, mb;

    initial begin
        add_done = 1'b0; add_sum = '0; add_overflow = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                pend = 1'b0; done_real = 1'b0; add_done = 1'b0;
                add_sum = '0; add_overflow = 1'b0;
            end else if (add_start) begin
                // Start will be sampled at the next edge; a stale done level stays.
                ma = add_a; mb = add_b;
                pend      = !no_resp;
                lat_cnt   = $urandom_range(lat_max, lat_min);
                done_real = 1'b0;
                if (!stale_mode) add_done = 1'b0;
            end else if (pend) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    add_done     = 1'b1;
                    add_sum      = {1'b0, ma} + {1'b0, mb};
                    add_overflow = model_ovf(ma, mb);
                    done_real    = 1'b1;
                    pend         = 1'b0;
                end else begin
                    add_done     = 1'b0;
                    add_sum      = 17'h0DEAD;
                    done_real    = 1'b0;
                end
            end else begin
                done_real = 1'b0;
                if (stale_mode) begin
                    add_done = 1'b1; add_sum = 17'h1ABCD; add_overflow = 1'b1;
                end else begin
                    add_done = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model + compare process (negedge, inputs are stable).
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] pairq[$];
    logic [WIDTH+2:0]   resq[$];      // {sum, overflow, timeout}
    int   acc = 0, popped = 0, issued = 0, consumed = 0;
    int   to_cnt = 0;
    int   cyc = 0;
    int   last_acc_edge = 0, last_start_edge = 0;
    bit   prev_ov = 0, prev_hs = 0, rst_prev = 0, exp_ov_next = 0;
    logic [WIDTH:0] prev_sum = '0;
    logic           prev_ovf = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic              rise;
        logic [2*WIDTH-1:0] p;
        logic [WIDTH+2:0]   e;
        if (rst_prev) begin
            check("rst_fifo_count", fifo_count, 0);
            check("rst_in_ready",   in_ready, 1);
            check("rst_outputs", {add_start, add_a, add_b, out_valid, out_sum,
                                  out_overflow, out_timeout, busy}, 0);
            pairq.delete(); resq.delete();
            acc = 0; popped = 0; issued = 0; consumed = 0; to_cnt = 0;
            prev_ov = 0; prev_hs = 0; exp_ov_next = 0;
        end else if (!reset) begin
            rise = out_valid && !prev_ov;
            if (exp_ov_next) check("result_latency", {out_valid, rise}, 2'b11);
            if (to_cnt > 0) begin
                to_cnt--;
                if (to_cnt == 0) check("timeout_latency", rise, 1);
                else             check("timeout_early", out_valid, 0);
            end
            if (rise) begin
                popped++;
                if (resq.size() == 0) check("result_unexpected", 1, 0);
                else begin
                    e = resq.pop_front();
                    check("result", {out_sum, out_overflow, out_timeout}, e);
                end
            end
            if (prev_ov && !prev_hs) begin
                check("out_valid_held", out_valid, 1);
                check("out_sum_held", {out_sum, out_overflow}, {prev_sum, prev_ovf});
            end
            check("fifo_count", fifo_count, acc - popped);
            check("in_ready", in_ready, (acc - popped) < DEPTH);
            check("busy", busy, ((acc - popped) != 0) || (issued != consumed) || add_start);
            if (add_start) begin
                check("one_job_at_a_time", issued - consumed, 0);
                if (pairq.size() == 0) check("start_without_job", 1, 0);
                else begin
                    p = pairq.pop_front();
                    check("operands", {add_a, add_b}, p);
                    if (no_resp) begin
                        resq.push_back({{(WIDTH+1){1'b0}}, 1'b0, 1'b1});
                        to_cnt = TIMEOUT + 1;
                    end else begin
                        resq.push_back({{1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[WIDTH-1:0]},
                                        model_ovf(p[2*WIDTH-1:WIDTH], p[WIDTH-1:0]), 1'b0});
                    end
                end
                issued++;
                last_start_edge = cyc;
            end
            exp_ov_next = add_done && done_real;
            prev_hs = out_valid && out_ready;
            if (prev_hs) consumed++;
            if (in_valid && in_ready) begin
                pairq.push_back({in_a, in_b});
                acc++;
                last_acc_edge = cyc;   // edge that opened the handshake cycle
            end
            prev_ov  = out_valid;
            prev_sum = out_sum;
            prev_ovf = out_overflow;
        end
        rst_prev = reset;
    end

    // ------------------------------------------------------------------
    // Drivers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int t = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 400) begin check("push_timeout", 1, 0); break; end
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [WIDTH:0] s, output logic o, output logic to);
        int t = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            t++;
            if (t > 400) begin check("result_wait_timeout", 1, 0); break; end
        end
        s = out_sum; o = out_overflow; to = out_timeout;
        @(posedge clk); #2;
    endtask

    task automatic drain();
        int t = 0;
        forever begin
            @(negedge clk);
            if (!busy && !out_valid && pairq.size() == 0 && resq.size() == 0) break;
            t++;
            if (t > 3000) begin check("drain_timeout", 1, 0); break; end
        end
        @(posedge clk); #2;
    endtask

    logic [WIDTH:0] r_s;
    logic           r_o, r_t;
    bit             rand_done;
    int             c0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_fifo_count", fifo_count, 0);
        @(posedge clk); #2;

        // Single job with latency pinned. A pair presented in the cycle
        // after edge N gives add_start in the cycle after edge N+2.
        lat_min = 2; lat_max = 2;
        c0 = issued;
        push_pair(16'd100, 16'd200);
        wait_result(r_s, r_o, r_t);
        check("single_sum", r_s, 17'd300);
        check("single_ovf", r_o, 0);
        check("issue_latency", last_start_edge - last_acc_edge, 2);
        check("single_start_count", issued - c0, 1);
        drain();
        check("single_fifo_empty", fifo_count, 0);

        // Overflow/sum pass-through.
        push_pair(16'd32767, 16'd32767);
        wait_result(r_s, r_o, r_t);
        check("ovf1_sum", r_s, 17'd65534);
        check("ovf1_flag", r_o, 1);
        push_pair(16'd32767, 16'd1);
        wait_result(r_s, r_o, r_t);
        check("ovf2_sum", r_s, 17'd32768);
        check("ovf2_flag", r_o, 0);

        // Stale done: high through IDLE/ISSUE, low for 3 WAIT cycles, then real.
        stale_mode = 1'b1; lat_min = 4; lat_max = 4;
        repeat (2) @(posedge clk); #2;
        push_pair(16'd5, 16'd6);
        wait_result(r_s, r_o, r_t);
        check("stale_sum1", r_s, 17'd11);
        push_pair(16'd1000, 16'd2000);
        wait_result(r_s, r_o, r_t);
        check("stale_sum2", r_s, 17'd3000);
        stale_mode = 1'b0;
        drain();

        // FIFO full with a slow adder and the consumer stalled.
        lat_min = 15; lat_max = 15; out_ready = 1'b0;
        c0 = consumed;
        for (int i = 0; i < 4; i++) push_pair(16'(10 + i), 16'(20 + i));
        in_valid = 1'b1; in_a = 16'd50; in_b = 16'd60;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
            check("full_count", fifo_count, 4);
        end
        @(posedge clk); #2;
        push_pair(16'd50, 16'd60);
        out_ready = 1'b1;
        drain();
        check("full_results_out", consumed - c0, 5);

        // Reset in WAIT with two entries queued.
        lat_min = 30; lat_max = 30;
        push_pair(16'd7, 16'd8);
        push_pair(16'd9, 16'd10);
        begin
            int t = 0;
            while (!add_start && t < 50) begin @(negedge clk); t++; end
        end
        repeat (3) @(posedge clk); #2;
        check("midjob_queued", fifo_count, 2);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("midjob_rst_count", fifo_count, 0);
        check("midjob_rst_valid", out_valid, 0);
        check("midjob_rst_start", add_start, 0);
        check("midjob_rst_busy", busy, 0);
        @(posedge clk); #2;
        lat_min = 2; lat_max = 2;
        push_pair(16'd1, 16'd2);
        wait_result(r_s, r_o, r_t);
        check("post_reset_sum", r_s, 17'd3);
        drain();

        // Randomized traffic with random adder latency and back-pressure.
        lat_min = 1; lat_max = 5; rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [WIDTH-1:0] a, b;
                    a = WIDTH'($urandom);
                    b = (i % 5 == 0) ? a : WIDTH'($urandom);
                    push_pair(a, b);
                    repeat ($urandom_range(2, 0)) @(posedge clk);
                    #0;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(3, 0) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef ADDER_DISPATCH_TIMEOUT_EN
        // Adder never answers the first job; the second completes normally.
        no_resp = 1'b1; out_ready = 1'b0;
        push_pair(16'd11, 16'd22);
        push_pair(16'd33, 16'd44);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin @(negedge clk); t++; end
        end
        check("timeout_flag", out_timeout, 1);
        check("timeout_sum", {out_sum, out_overflow}, 0);
        @(posedge clk); #2;
        no_resp = 1'b0; lat_min = 2; lat_max = 2; out_ready = 1'b1;
        @(posedge clk); #2;
        wait_result(r_s, r_o, r_t);
        check("after_timeout_sum", r_s, 17'd77);
        check("after_timeout_flag", r_t, 0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
